// File: rtl/rs_ddr_w_skid.sv
// rs_ddr_w_skid -- register slice for an AXI write path (AW, W, B).
//
// Each channel passes through an independent two-entry skid slice: a main
// register drives the output side and a skid register catches the one beat
// that arrives while the output is stalled. Every ready output comes
// straight from a flop, so no combinational path crosses the slice.
//
// Ports:
//   user_clk, reset_n              clock, asynchronous active-low reset
//   m_axi_cd_aw*_rs / m_axi_cd_aw* upstream / downstream AW
//   m_axi_cd_w*_rs  / m_axi_cd_w*  upstream / downstream W
//   m_axi_cd_b*     / m_axi_cd_b*_rs downstream / upstream B
//   outs_cnt                       accepted-but-unretired AW bursts
//   berr_clr, berr_cnt             B error counter clear / value
//
// Build option: define RS_DDR_W_BERR_CNT_EN to count B responses with
// bresp[1] set (SLVERR/DECERR). Without it berr_cnt is tied to 0.

module rs_ddr_w_skid_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy,
    input  logic         blk_d      // hold ready low next cycle
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         rdy_q, rdy_d;
    logic         in_hs;

    always_comb begin
        vld_d       = vld_q;
        data_d      = data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        in_hs       = in_vld && rdy_q;
        if (!vld_q || out_rdy) begin
            // Main is free this edge: refill from skid first to keep order.
            // A full skid implies rdy_q == 0, so in_hs cannot also fire.
            if (skid_vld_q) begin
                vld_d      = 1'b1;
                data_d     = skid_data_q;
                skid_vld_d = 1'b0;
            end else begin
                vld_d = in_hs;
                if (in_hs) data_d = in_data;
            end
        end else if (in_hs) begin
            skid_vld_d  = 1'b1;
            skid_data_d = in_data;
        end
        // Ready is the registered "skid will be empty" flag.
        rdy_d = !skid_vld_d && !blk_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= 1'b0;
            data_q      <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            rdy_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            data_q      <= data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            rdy_q       <= rdy_d;
        end
    end

    assign in_rdy   = rdy_q;
    assign out_vld  = vld_q;
    assign out_data = data_q;
endmodule

module rs_ddr_w_skid #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int LEN_W    = 8,
    parameter int MAX_OUTS = 16,
    localparam int CW      = $clog2(MAX_OUTS + 1)
) (
    input  logic              user_clk,
    input  logic              reset_n,
    input  logic              m_axi_cd_awvalid_rs,
    input  logic [ADDR_W-1:0] m_axi_cd_awaddr_rs,
    input  logic [LEN_W-1:0]  m_axi_cd_awlen_rs,
    output logic              m_axi_cd_awready_rs,
    output logic              m_axi_cd_awvalid,
    output logic [ADDR_W-1:0] m_axi_cd_awaddr,
    output logic [LEN_W-1:0]  m_axi_cd_awlen,
    input  logic              m_axi_cd_awready,
    input  logic              m_axi_cd_wvalid_rs,
    input  logic [DATA_W-1:0] m_axi_cd_wdata_rs,
    input  logic              m_axi_cd_wlast_rs,
    output logic              m_axi_cd_wready_rs,
    output logic              m_axi_cd_wvalid,
    output logic [DATA_W-1:0] m_axi_cd_wdata,
    output logic              m_axi_cd_wlast,
    input  logic              m_axi_cd_wready,
    input  logic              m_axi_cd_bvalid,
    input  logic [1:0]        m_axi_cd_bresp,
    output logic              m_axi_cd_bready,
    output logic              m_axi_cd_bvalid_rs,
    output logic [1:0]        m_axi_cd_bresp_rs,
    input  logic              m_axi_cd_bready_rs,
    output logic [CW-1:0]     outs_cnt,
    input  logic              berr_clr,
    output logic [15:0]       berr_cnt
);
    logic [CW-1:0] outs_cnt_q, outs_cnt_d;
    logic          aw_acc, b_ret, aw_blk_d;

    rs_ddr_w_skid_slice #(.W(ADDR_W + LEN_W)) u_aw (
        .clk(user_clk), .rst_n(reset_n),
        .in_vld(m_axi_cd_awvalid_rs),
        .in_data({m_axi_cd_awaddr_rs, m_axi_cd_awlen_rs}),
        .in_rdy(m_axi_cd_awready_rs),
        .out_vld(m_axi_cd_awvalid),
        .out_data({m_axi_cd_awaddr, m_axi_cd_awlen}),
        .out_rdy(m_axi_cd_awready),
        .blk_d(aw_blk_d)
    );

    rs_ddr_w_skid_slice #(.W(DATA_W + 1)) u_w (
        .clk(user_clk), .rst_n(reset_n),
        .in_vld(m_axi_cd_wvalid_rs),
        .in_data({m_axi_cd_wlast_rs, m_axi_cd_wdata_rs}),
        .in_rdy(m_axi_cd_wready_rs),
        .out_vld(m_axi_cd_wvalid),
        .out_data({m_axi_cd_wlast, m_axi_cd_wdata}),
        .out_rdy(m_axi_cd_wready),
        .blk_d(1'b0)
    );

    rs_ddr_w_skid_slice #(.W(2)) u_b (
        .clk(user_clk), .rst_n(reset_n),
        .in_vld(m_axi_cd_bvalid),
        .in_data(m_axi_cd_bresp),
        .in_rdy(m_axi_cd_bready),
        .out_vld(m_axi_cd_bvalid_rs),
        .out_data(m_axi_cd_bresp_rs),
        .out_rdy(m_axi_cd_bready_rs),
        .blk_d(1'b0)
    );

    // Outstanding-burst tracking; a stray B at zero is ignored.
    always_comb begin
        aw_acc     = m_axi_cd_awvalid_rs && m_axi_cd_awready_rs;
        b_ret      = m_axi_cd_bvalid_rs && m_axi_cd_bready_rs;
        outs_cnt_d = outs_cnt_q;
        if (aw_acc && !b_ret)
            outs_cnt_d = outs_cnt_q + 1'b1;
        else if (b_ret && !aw_acc && outs_cnt_q != '0)
            outs_cnt_d = outs_cnt_q - 1'b1;
        aw_blk_d = (outs_cnt_d == CW'(MAX_OUTS));
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) outs_cnt_q <= '0;
        else          outs_cnt_q <= outs_cnt_d;
    end

    assign outs_cnt = outs_cnt_q;

`ifdef RS_DDR_W_BERR_CNT_EN
    logic [15:0] berr_cnt_q, berr_cnt_d;

    always_comb begin
        berr_cnt_d = berr_cnt_q;
        if (berr_clr)
            berr_cnt_d = '0;
        else if (b_ret && m_axi_cd_bresp_rs[1] && berr_cnt_q != 16'hFFFF)
            berr_cnt_d = berr_cnt_q + 16'd1;
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) berr_cnt_q <= '0;
        else          berr_cnt_q <= berr_cnt_d;
    end

    assign berr_cnt = berr_cnt_q;
`else
    logic unused_berr_clr;
    assign unused_berr_clr = berr_clr;
    assign berr_cnt        = '0;
`endif
endmodule

// File: tb/tb_rs_ddr_w_skid.sv
module tb_rs_ddr_w_skid;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);
`ifdef RS_DDR_W_BERR_CNT_EN
    localparam bit BERR_EN = 1'b1;
`else
    localparam bit BERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          awvalid_rs, awready_rs, awvalid, awready;
    logic [AW-1:0] awaddr_rs, awaddr;
    logic [LW-1:0] awlen_rs, awlen;
    logic          wvalid_rs, wready_rs, wvalid, wready, wlast_rs, wlast;
    logic [DW-1:0] wdata_rs, wdata;
    logic          bvalid, bready, bvalid_rs, bready_rs;
    logic [1:0]    bresp, bresp_rs;
    logic [CW-1:0] outs_cnt;
    logic          berr_clr;
    logic [15:0]   berr_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rs_ddr_w_skid #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_OUTS(MO)) dut (
        .user_clk(clk), .reset_n(rst_n),
        .m_axi_cd_awvalid_rs(awvalid_rs), .m_axi_cd_awaddr_rs(awaddr_rs),
        .m_axi_cd_awlen_rs(awlen_rs), .m_axi_cd_awready_rs(awready_rs),
        .m_axi_cd_awvalid(awvalid), .m_axi_cd_awaddr(awaddr),
        .m_axi_cd_awlen(awlen), .m_axi_cd_awready(awready),
        .m_axi_cd_wvalid_rs(wvalid_rs), .m_axi_cd_wdata_rs(wdata_rs),
        .m_axi_cd_wlast_rs(wlast_rs), .m_axi_cd_wready_rs(wready_rs),
        .m_axi_cd_wvalid(wvalid), .m_axi_cd_wdata(wdata),
        .m_axi_cd_wlast(wlast), .m_axi_cd_wready(wready),
        .m_axi_cd_bvalid(bvalid), .m_axi_cd_bresp(bresp),
        .m_axi_cd_bready(bready), .m_axi_cd_bvalid_rs(bvalid_rs),
        .m_axi_cd_bresp_rs(bresp_rs), .m_axi_cd_bready_rs(bready_rs),
        .outs_cnt(outs_cnt), .berr_clr(berr_clr), .berr_cnt(berr_cnt)
    );

    task automatic idle_inputs();
        awvalid_rs = 0; awaddr_rs = '0; awlen_rs = '0; awready = 1;
        wvalid_rs = 0; wdata_rs = '0; wlast_rs = 0; wready = 1;
        bvalid = 0; bresp = 2'b00; bready_rs = 1; berr_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready_rs, wready_rs, bready} !== 3'b000) begin
            failures++; $display("FAIL reset_ready got=%b want=000", {awready_rs, wready_rs, bready});
        end
        checks++;
        if ({awvalid, wvalid, bvalid_rs} !== 3'b000) begin
            failures++; $display("FAIL reset_valid got=%b want=000", {awvalid, wvalid, bvalid_rs});
        end
        checks++;
        if (outs_cnt !== '0 || berr_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", outs_cnt, berr_cnt);
        end
        rst_n = 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready_rs, wready_rs, bready} !== 3'b111) begin
            failures++; $display("FAIL reset_release_ready got=%b want=111", {awready_rs, wready_rs, bready});
        end
    endtask

    task automatic test_single_burst();
        logic [DW-1:0] d [4];
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        @(posedge clk); #1;
        awvalid_rs = 1; awaddr_rs = 32'h1000; awlen_rs = 8'd3;
        wvalid_rs = 1; wdata_rs = d[0]; wlast_rs = 0;
        @(negedge clk);
        checks++;
        if ({awready_rs, wready_rs} !== 2'b11) begin
            failures++; $display("FAIL single_in_ready got=%b want=11", {awready_rs, wready_rs});
        end
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            awvalid_rs = 0;
            if (i < 4) begin
                wdata_rs = d[i]; wlast_rs = (i == 3);
            end else begin
                wvalid_rs = 0; wlast_rs = 0;
            end
            @(negedge clk);
            if (i <= 4) begin
                checks++;
                if (wvalid !== 1'b1 || wdata !== d[i-1] || wlast !== (i == 4)) begin
                    failures++;
                    $display("FAIL single_w%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             i - 1, wvalid, wdata, wlast, d[i-1], i == 4);
                end
            end else begin
                checks++;
                if (wvalid !== 1'b0) begin
                    failures++; $display("FAIL single_w_done got=%b want=0", wvalid);
                end
            end
            if (i == 1) begin
                checks++;
                if (awvalid !== 1'b1 || awaddr !== 32'h1000 || awlen !== 8'd3) begin
                    failures++;
                    $display("FAIL single_aw got v=%b a=%h l=%0d want v=1 a=1000 l=3", awvalid, awaddr, awlen);
                end
            end
            if (i == 2) begin
                checks++;
                if (awvalid !== 1'b0) begin
                    failures++; $display("FAIL single_aw_once got=%b want=0", awvalid);
                end
            end
        end
    endtask

    task automatic test_w_stall();
        logic [DW-1:0] d [8];
        int sent = 0, rcv = 0, gapless = 0;
        do_reset();
        for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            wready    = !(k >= 3 && k <= 5);
            wvalid_rs = (sent < 8);
            wdata_rs  = (sent < 8) ? d[sent] : '0;
            wlast_rs  = (sent == 7);
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (wready_rs !== 1'b0) begin
                    failures++; $display("FAIL stall_wready_drop got=%b want=0", wready_rs);
                end
                checks++;
                if (wvalid !== 1'b1 || wdata !== d[2]) begin
                    failures++; $display("FAIL stall_hold got v=%b d=%h want v=1 d=%h", wvalid, wdata, d[2]);
                end
            end
            if (k == 7) begin
                checks++;
                if (wready_rs !== 1'b1) begin
                    failures++; $display("FAIL stall_wready_back got=%b want=1", wready_rs);
                end
            end
            if (wvalid && wready) begin
                checks++;
                if (rcv >= 8 || wdata !== d[rcv] || wlast !== (rcv == 7)) begin
                    failures++; $display("FAIL stall_order idx=%0d got=%h l=%b", rcv, wdata, wlast);
                end
                if (k >= 6 && k <= 11) gapless++;
                rcv++;
            end
            if (wvalid_rs && wready_rs) sent++;
        end
        idle_inputs();
        checks++;
        if (rcv !== 8 || gapless !== 6) begin
            failures++; $display("FAIL stall_count got rcv=%0d gapless=%0d want 8/6", rcv, gapless);
        end
    endtask

    task automatic test_outs_limit();
        int acc = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            awvalid_rs = 1; awaddr_rs = 32'h100 * (acc + 1); awlen_rs = 8'(acc);
            @(negedge clk);
            if (awvalid_rs && awready_rs) acc++;
        end
        checks++;
        if (acc !== 2 || awready_rs !== 1'b0 || outs_cnt !== 2'd2) begin
            failures++; $display("FAIL limit_stall got acc=%0d rdy=%b cnt=%0d want 2/0/2", acc, awready_rs, outs_cnt);
        end
        @(posedge clk); #1;
        bvalid = 1; bresp = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;
        bvalid = 0;
        @(negedge clk);
        checks++;
        if (bvalid_rs !== 1'b1 || awready_rs !== 1'b0) begin
            failures++; $display("FAIL limit_bret got bv=%b rdy=%b want 1/0", bvalid_rs, awready_rs);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (awready_rs !== 1'b1 || outs_cnt !== 2'd1) begin
            failures++; $display("FAIL limit_reopen got rdy=%b cnt=%0d want 1/1", awready_rs, outs_cnt);
        end
        @(posedge clk); #1;
        awvalid_rs = 0;
        @(negedge clk);
        checks++;
        if (outs_cnt !== 2'd2 || awready_rs !== 1'b0) begin
            failures++; $display("FAIL limit_third got cnt=%0d rdy=%b want 2/0", outs_cnt, awready_rs);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        @(posedge clk); #1;
        awvalid_rs = 1; awaddr_rs = 32'hA0;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid_rs = 0; bvalid = 1;
        @(negedge clk);
        @(posedge clk); #1;
        bvalid = 0; awvalid_rs = 1; awaddr_rs = 32'hB0;
        @(negedge clk);
        checks++;
        if (outs_cnt !== 2'd1 || !(bvalid_rs && bready_rs) || awready_rs !== 1'b1) begin
            failures++;
            $display("FAIL same_setup got cnt=%0d bv=%b awr=%b want 1/1/1", outs_cnt, bvalid_rs, awready_rs);
        end
        @(posedge clk); #1;
        awvalid_rs = 0;
        @(negedge clk);
        checks++;
        if (outs_cnt !== 2'd1) begin
            failures++; $display("FAIL same_cycle_cnt got=%0d want=1", outs_cnt);
        end
    endtask

    task automatic test_berr();
        logic [1:0] resp [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bvalid = 1; bresp = resp[i];
            @(negedge clk);
        end
        @(posedge clk); #1;
        bvalid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (berr_cnt !== (BERR_EN ? 16'd2 : 16'd0)) begin
            failures++; $display("FAIL berr_count got=%0d want=%0d", berr_cnt, BERR_EN ? 2 : 0);
        end
        // error response retiring in the same cycle as the clear
        @(posedge clk); #1;
        bvalid = 1; bresp = 2'b10;
        @(posedge clk); #1;
        bvalid = 0; berr_clr = 1;
        @(negedge clk);
        checks++;
        if (!(bvalid_rs && bready_rs) || bresp_rs !== 2'b10) begin
            failures++; $display("FAIL berr_clr_setup got v=%b r=%b want 1/10", bvalid_rs, bresp_rs);
        end
        @(posedge clk); #1;
        berr_clr = 0;
        @(negedge clk);
        checks++;
        if (berr_cnt !== 16'd0) begin
            failures++; $display("FAIL berr_clear got=%0d want=0", berr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        awready = 0; wready = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            awvalid_rs = 1; awaddr_rs = $urandom; awlen_rs = 8'(i);
            wvalid_rs = 1; wdata_rs = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        awvalid_rs = 0; wvalid_rs = 0;
        @(negedge clk);
        checks++;
        if ({awready_rs, wready_rs, awvalid, wvalid} !== 4'b0011) begin
            failures++; $display("FAIL mid_full got=%b want=0011", {awready_rs, wready_rs, awvalid, wvalid});
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({awvalid, wvalid, bvalid_rs} !== 3'b000 || outs_cnt !== '0) begin
            failures++; $display("FAIL mid_async got=%b cnt=%0d want 000/0", {awvalid, wvalid, bvalid_rs}, outs_cnt);
        end
        @(posedge clk); #2;
        rst_n = 1;
        awready = 1; wready = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({awvalid, wvalid, bvalid_rs} !== 3'b000 || outs_cnt !== '0) begin
                failures++; $display("FAIL mid_stale c%0d got=%b cnt=%0d want 000/0", k, {awvalid, wvalid, bvalid_rs}, outs_cnt);
            end
        end
    endtask

    // Random traffic on all three channels against FIFO/counter model.
    task automatic test_random();
        logic [AW+LW-1:0] aw_q[$];
        logic [DW:0]      w_q[$];
        logic [1:0]       b_q[$];
        int               ref_cnt = 0;
        int               ref_berr = 0;
        bit m_awr, m_wr, m_br, aw_in, aw_out, w_in, w_out, b_in, b_out;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            awvalid_rs = $urandom_range(0, 1); awaddr_rs = $urandom; awlen_rs = 8'($urandom);
            awready    = ($urandom_range(0, 9) < 7);
            wvalid_rs  = $urandom_range(0, 1); wdata_rs = {$urandom, $urandom};
            wlast_rs   = $urandom_range(0, 1);
            wready     = ($urandom_range(0, 9) < 6);
            bvalid     = ($urandom_range(0, 2) == 0); bresp = 2'($urandom);
            bready_rs  = ($urandom_range(0, 9) < 7);
            berr_clr   = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            m_awr = (aw_q.size() < 2) && (ref_cnt != MO);
            m_wr  = (w_q.size() < 2);
            m_br  = (b_q.size() < 2);
            checks++;
            if ({awready_rs, wready_rs, bready} !== {m_awr, m_wr, m_br}) begin
                failures++; $display("FAIL rnd_ready c%0d got=%b want=%b", cyc, {awready_rs, wready_rs, bready}, {m_awr, m_wr, m_br});
            end
            checks++;
            if ({awvalid, wvalid, bvalid_rs} !== {aw_q.size() > 0, w_q.size() > 0, b_q.size() > 0}) begin
                failures++; $display("FAIL rnd_valid c%0d got=%b want=%b", cyc, {awvalid, wvalid, bvalid_rs},
                                     {aw_q.size() > 0, w_q.size() > 0, b_q.size() > 0});
            end
            if (aw_q.size() > 0) begin
                checks++;
                if ({awaddr, awlen} !== aw_q[0]) begin
                    failures++; $display("FAIL rnd_aw c%0d got=%h want=%h", cyc, {awaddr, awlen}, aw_q[0]);
                end
            end
            if (w_q.size() > 0) begin
                checks++;
                if ({wlast, wdata} !== w_q[0]) begin
                    failures++; $display("FAIL rnd_w c%0d got=%h want=%h", cyc, {wlast, wdata}, w_q[0]);
                end
            end
            if (b_q.size() > 0) begin
                checks++;
                if (bresp_rs !== b_q[0]) begin
                    failures++; $display("FAIL rnd_b c%0d got=%b want=%b", cyc, bresp_rs, b_q[0]);
                end
            end
            checks++;
            if (outs_cnt !== CW'(ref_cnt) || berr_cnt !== 16'(ref_berr)) begin
                failures++; $display("FAIL rnd_cnt c%0d got=%0d/%0d want=%0d/%0d", cyc, outs_cnt, berr_cnt, ref_cnt, ref_berr);
            end
            aw_in  = awvalid_rs && m_awr;
            aw_out = (aw_q.size() > 0) && awready;
            w_in   = wvalid_rs && m_wr;
            w_out  = (w_q.size() > 0) && wready;
            b_in   = bvalid && m_br;
            b_out  = (b_q.size() > 0) && bready_rs;
            if (BERR_EN) begin
                if (berr_clr) ref_berr = 0;
                else if (b_out && b_q[0][1] && ref_berr < 16'hFFFF) ref_berr++;
            end
            if (aw_in && !b_out) ref_cnt++;
            else if (b_out && !aw_in && ref_cnt > 0) ref_cnt--;
            if (aw_out) void'(aw_q.pop_front());
            if (w_out) void'(w_q.pop_front());
            if (b_out) void'(b_q.pop_front());
            if (aw_in) aw_q.push_back({awaddr_rs, awlen_rs});
            if (w_in) w_q.push_back({wlast_rs, wdata_rs});
            if (b_in) b_q.push_back(bresp);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_burst();
        test_w_stall();
        test_outs_limit();
        test_same_cycle();
        test_berr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
